// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece datapath.
//  FIELD_W/FIELD_H : playfield geometry in cells
//  POS_W           : width of a piece coordinate
//  BLK_W           : bits in a 4x4 piece bitmap
//  state_e         : piece controller states
//  row_inc_sat     : row increment that saturates at the last encodable row
package tetris_pkg;

  localparam int FIELD_W = 20;
  localparam int FIELD_H = 20;
  localparam int POS_W   = 5;
  localparam int BLK_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_CHECK = 3'd2,
    ST_FALL  = 3'd3,
    ST_LOCK  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  // Row + 1, held at the maximum so the row never wraps back to the top.
  function automatic logic [POS_W-1:0] row_inc_sat(input logic [POS_W-1:0] v);
    if (v == {POS_W{1'b1}}) begin
      return v;
    end else begin
      return v + POS_W'(1);
    end
  endfunction

endpackage

// File: rtl/piece_move_ctrl_gravity_timer.sv
// Gravity timer: free-running count of enabled cycles, wrapping every
// GRAV_TICKS cycles and flagging the wrap with a one-cycle tick.
//  clock  in  system clock
//  reset  in  asynchronous active-high reset, count -> 0
//  clear  in  restart the count at 0 (wins over enable, suppresses tick)
//  enable in  advance the count this cycle
//  tick   out count is wrapping on this clock edge
module gravity_timer
  import tetris_pkg::*;
#(
  parameter int GRAV_TICKS = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (GRAV_TICKS > 2) ? $clog2(GRAV_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAV_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, wrap at CNT_MAX, advance, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable & ~clear & (cnt_q == CNT_MAX);

endmodule

// File: rtl/piece_move_ctrl.sv
// Active-piece controller. Spawns a piece from the generator, applies
// player moves and gravity when the move predictor allows them, requests a
// field write when the piece lands and flags game over on a blocked spawn.
//  clock/reset            clock, asynchronous active-high reset
//  game_en                1 = run, 0 = freeze everything
//  btn_*                  one-cycle move pulses (rotate > left > right > drop)
//  *_ok, spawn_ok         predictor verdicts for the registered piece
//  rot_block              clockwise-rotated current piece
//  next_block/next_valid  generator piece; next_ready accepts it
//  block/block_x/block_y  registered active piece and position
//  lock_req/lock_ack      field write handshake
//  piece_active           piece is falling
//  game_over              sticky spawn-collision flag
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int               GRAV_TICKS = 25_000_000,
  parameter logic [POS_W-1:0] SPAWN_X    = 5'd8,
  parameter logic [POS_W-1:0] SPAWN_Y    = 5'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             game_en,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rotate,
  input  logic             btn_drop,
  input  logic             left_ok,
  input  logic             right_ok,
  input  logic             rotate_ok,
  input  logic             down_ok,
  input  logic             spawn_ok,
  input  logic [0:BLK_W-1] rot_block,
  input  logic [0:BLK_W-1] next_block,
  input  logic             next_valid,
  output logic             next_ready,
  output logic [0:BLK_W-1] block,
  output logic [POS_W-1:0] block_x,
  output logic [POS_W-1:0] block_y,
  output logic             lock_req,
  input  logic             lock_ack,
  output logic             piece_active,
  output logic             game_over
);

  state_e             state_q, state_d;
  logic [0:BLK_W-1]   block_q, block_d;
  logic [POS_W-1:0]   x_q, x_d;
  logic [POS_W-1:0]   y_q, y_d;
  logic               pend_q, pend_d;
  logic               lock_req_q, lock_req_d;

  logic drop_sel;
  logic grav_clear;
  logic grav_en;
  logic grav_tick;

  // Soft drop only acts when no higher-priority button is present.
  assign drop_sel   = btn_drop & ~btn_rotate & ~btn_left & ~btn_right;
  // Restart the count on a spawn load and on a successful soft drop.
  assign grav_clear = game_en & (((state_q == ST_SPAWN) & next_valid) |
                                 ((state_q == ST_FALL) & drop_sel & down_ok));
  assign grav_en    = game_en & (state_q == ST_FALL);

  gravity_timer #(
    .GRAV_TICKS (GRAV_TICKS)
  ) u_gravity_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (grav_clear),
    .enable (grav_en),
    .tick   (grav_tick)
  );

  // Next-state and piece update; at most one action per cycle.
  always_comb begin
    state_d = state_q;
    block_d = block_q;
    x_d     = x_q;
    y_d     = y_q;
    pend_d  = pend_q;
    if (game_en) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SPAWN;
        end
        ST_SPAWN: begin
          if (next_valid) begin
            block_d = next_block;
            x_d     = SPAWN_X;
            y_d     = SPAWN_Y;
            pend_d  = 1'b0;
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SPAWN;
          end
        end
        ST_CHECK: begin
          state_d = spawn_ok ? ST_FALL : ST_OVER;
        end
        ST_FALL: begin
          // A wrap always leaves gravity pending; consuming it below
          // keeps only a wrap from this very cycle.
          pend_d = pend_q | grav_tick;
          if (btn_rotate) begin
            block_d = rotate_ok ? rot_block : block_q;
          end else if (btn_left) begin
            x_d = left_ok ? (x_q - POS_W'(1)) : x_q;
          end else if (btn_right) begin
            x_d = right_ok ? (x_q + POS_W'(1)) : x_q;
          end else if (btn_drop || pend_q) begin
            if (down_ok) begin
              y_d    = row_inc_sat(y_q);
              pend_d = grav_tick;
            end else begin
              state_d = ST_LOCK;
            end
          end else begin
            state_d = ST_FALL;
          end
        end
        ST_LOCK: begin
          state_d = lock_ack ? ST_SPAWN : ST_LOCK;
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    lock_req_d = (state_d == ST_LOCK);
  end

  // State and piece registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      block_q    <= {BLK_W{1'b0}};
      x_q        <= SPAWN_X;
      y_q        <= SPAWN_Y;
      pend_q     <= 1'b0;
      lock_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pend_q     <= pend_d;
      lock_req_q <= lock_req_d;
    end
  end

  assign next_ready   = game_en & (state_q == ST_SPAWN);
  assign block        = block_q;
  assign block_x      = x_q;
  assign block_y      = y_q;
  assign lock_req     = lock_req_q;
  assign piece_active = (state_q == ST_FALL);
  assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_piece_move_ctrl.sv
// Directed and randomized bench for piece_move_ctrl with a behavioural model.
module tb_piece_move_ctrl;

  localparam int GRAV = 4;

  localparam int M_IDLE  = 0;
  localparam int M_SPAWN = 1;
  localparam int M_CHECK = 2;
  localparam int M_FALL  = 3;
  localparam int M_LOCK  = 4;
  localparam int M_OVER  = 5;

  logic        clock;
  logic        reset;
  logic        game_en;
  logic        btn_left, btn_right, btn_rotate, btn_drop;
  logic        left_ok, right_ok, rotate_ok, down_ok, spawn_ok;
  logic [0:15] rot_block, next_block;
  logic        next_valid;
  logic        next_ready;
  logic [0:15] block;
  logic [4:0]  block_x, block_y;
  logic        lock_req, lock_ack;
  logic        piece_active, game_over;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the piece controller.
  int          m_mode;
  logic [0:15] m_block;
  logic [4:0]  m_x, m_y;
  int          m_cnt;
  bit          m_pend;

  piece_move_ctrl #(
    .GRAV_TICKS (GRAV),
    .SPAWN_X    (5'd8),
    .SPAWN_Y    (5'd0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .game_en      (game_en),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_rotate   (btn_rotate),
    .btn_drop     (btn_drop),
    .left_ok      (left_ok),
    .right_ok     (right_ok),
    .rotate_ok    (rotate_ok),
    .down_ok      (down_ok),
    .spawn_ok     (spawn_ok),
    .rot_block    (rot_block),
    .next_block   (next_block),
    .next_valid   (next_valid),
    .next_ready   (next_ready),
    .block        (block),
    .block_x      (block_x),
    .block_y      (block_y),
    .lock_req     (lock_req),
    .lock_ack     (lock_ack),
    .piece_active (piece_active),
    .game_over    (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_block = 16'h0000;
    m_x     = 5'd8;
    m_y     = 5'd0;
    m_cnt   = 0;
    m_pend  = 1'b0;
  endtask

  // One clock edge of the game rules, using the inputs applied this cycle.
  task automatic model_edge();
    bit tick;
    if (!game_en) return;
    case (m_mode)
      M_IDLE:  m_mode = M_SPAWN;
      M_SPAWN: if (next_valid) begin
        m_block = next_block; m_x = 5'd8; m_y = 5'd0;
        m_cnt = 0; m_pend = 1'b0; m_mode = M_CHECK;
      end
      M_CHECK: m_mode = spawn_ok ? M_FALL : M_OVER;
      M_FALL: begin
        tick  = (m_cnt == GRAV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (btn_rotate) begin
          if (rotate_ok) m_block = rot_block;
        end else if (btn_left) begin
          if (left_ok) m_x = m_x - 5'd1;
        end else if (btn_right) begin
          if (right_ok) m_x = m_x + 5'd1;
        end else if (btn_drop) begin
          if (down_ok) begin
            if (m_y != 5'd31) m_y = m_y + 5'd1;
            m_pend = 1'b0; m_cnt = 0; tick = 1'b0;
          end else m_mode = M_LOCK;
        end else if (m_pend) begin
          if (down_ok) begin
            if (m_y != 5'd31) m_y = m_y + 5'd1;
            m_pend = 1'b0;
          end else m_mode = M_LOCK;
        end
        if (tick) m_pend = 1'b1;
      end
      M_LOCK:  if (lock_ack) m_mode = M_SPAWN;
      default: ;
    endcase
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "_block"},  32'(block),        32'(m_block));
    chk({pfx, "_x"},      32'(block_x),      32'(m_x));
    chk({pfx, "_y"},      32'(block_y),      32'(m_y));
    chk({pfx, "_lock"},   32'(lock_req),     32'(m_mode == M_LOCK));
    chk({pfx, "_active"}, 32'(piece_active), 32'(m_mode == M_FALL));
    chk({pfx, "_over"},   32'(game_over),    32'(m_mode == M_OVER));
    chk({pfx, "_ready"},  32'(next_ready),   32'((m_mode == M_SPAWN) && game_en));
  endtask

  task automatic step(input string pfx);
    @(posedge clock);
    model_edge();
    #1;
    check_all(pfx);
  endtask

  // Reset raised between edges; outputs must clear before the next edge.
  task automatic async_reset(input string pfx);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(pfx);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; game_en = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0; btn_drop = 1'b0;
    left_ok = 1'b0; right_ok = 1'b0; rotate_ok = 1'b0; down_ok = 1'b0;
    spawn_ok = 1'b0; rot_block = 16'h0000; next_block = 16'h0000;
    next_valid = 1'b0; lock_ack = 1'b0;
    model_reset();
    #3 check_all("rst");
    #4 reset = 1'b0;

    // 1: spawn of the O piece
    game_en = 1'b1; next_valid = 1'b1; next_block = 16'h0660;
    spawn_ok = 1'b1; down_ok = 1'b1;
    step("t1a"); chk("t1_ready_spawn", 32'(next_ready), 32'd1);
    step("t1b"); chk("t1_ready_check", 32'(next_ready), 32'd0);
    chk("t1_block", 32'(block), 32'h0660);
    next_valid = 1'b0;
    step("t1c"); chk("t1_x", 32'(block_x), 32'd8);
    chk("t1_y", 32'(block_y), 32'd0); chk("t1_active", 32'(piece_active), 32'd1);

    // 2: rotate beats left; a refused rotate does nothing at all
    btn_left = 1'b1; btn_rotate = 1'b1; left_ok = 1'b1; rotate_ok = 1'b1;
    rot_block = 16'h4460;
    step("t2a"); chk("t2_rot_block", 32'(block), 32'h4460);
    chk("t2_rot_x", 32'(block_x), 32'd8);
    rotate_ok = 1'b0; rot_block = 16'h0F00;
    step("t2b"); chk("t2_norot_block", 32'(block), 32'h4460);
    chk("t2_norot_x", 32'(block_x), 32'd8);
    btn_left = 1'b0; btn_rotate = 1'b0;

    // 3: gravity every 4 cycles; a button on the gravity cycle wins
    step("t3a"); step("t3b"); chk("t3_y_before", 32'(block_y), 32'd0);
    step("t3c"); chk("t3_y_first", 32'(block_y), 32'd1);
    step("t3d"); step("t3e"); step("t3f");
    btn_right = 1'b1; right_ok = 1'b1;
    step("t3g"); chk("t3_right_x", 32'(block_x), 32'd9);
    chk("t3_right_y", 32'(block_y), 32'd1);
    btn_right = 1'b0;
    step("t3h"); chk("t3_late_y", 32'(block_y), 32'd2);

    // 4: landing, lock handshake acknowledged after 3 cycles
    down_ok = 1'b0;
    step("t4a"); step("t4b"); chk("t4_still_fall", 32'(piece_active), 32'd1);
    step("t4c"); chk("t4_lock_req", 32'(lock_req), 32'd1);
    step("t4d"); step("t4e"); chk("t4_lock_held", 32'(lock_req), 32'd1);
    lock_ack = 1'b1;
    step("t4f"); chk("t4_lock_drop", 32'(lock_req), 32'd0);
    chk("t4_respawn_ready", 32'(next_ready), 32'd1);
    lock_ack = 1'b0;

    // 5: blocked spawn is sticky game over
    next_valid = 1'b1; next_block = 16'hF000; spawn_ok = 1'b0;
    step("t5a"); next_valid = 1'b0;
    step("t5b"); chk("t5_over", 32'(game_over), 32'd1);
    btn_drop = 1'b1; down_ok = 1'b1; btn_left = 1'b1; spawn_ok = 1'b1;
    step("t5c"); step("t5d");
    chk("t5_over_sticky", 32'(game_over), 32'd1);
    chk("t5_frozen_x", 32'(block_x), 32'd8);
    btn_drop = 1'b0; btn_left = 1'b0;

    // 6: asynchronous reset from OVER, mid-LOCK and mid-count
    async_reset("t6_over");
    next_valid = 1'b1; next_block = 16'h0E40; spawn_ok = 1'b1; down_ok = 1'b1;
    step("t6a"); step("t6b"); step("t6c");
    next_valid = 1'b0; btn_drop = 1'b1; down_ok = 1'b0;
    step("t6d"); chk("t6_in_lock", 32'(lock_req), 32'd1);
    btn_drop = 1'b0;
    step("t6e");
    async_reset("t6_lock"); chk("t6_lock_cleared", 32'(lock_req), 32'd0);
    next_valid = 1'b1; down_ok = 1'b1;
    step("t6f"); step("t6g"); step("t6h");
    next_valid = 1'b0;
    step("t6i"); step("t6j");
    async_reset("t6_cnt");
    next_valid = 1'b1;
    for (int i = 0; i < 8; i++) step("t6k");

    // Randomized play against the model
    for (int n = 0; n < 3000; n++) begin
      game_en    = ($urandom_range(0, 9) != 0);
      btn_rotate = ($urandom_range(0, 7) == 0);
      btn_left   = ($urandom_range(0, 5) == 0);
      btn_right  = ($urandom_range(0, 5) == 0);
      btn_drop   = ($urandom_range(0, 5) == 0);
      left_ok    = 1'($urandom_range(0, 1));
      right_ok   = 1'($urandom_range(0, 1));
      rotate_ok  = 1'($urandom_range(0, 1));
      down_ok    = ($urandom_range(0, 7) != 0);
      spawn_ok   = ($urandom_range(0, 9) != 0);
      next_valid = 1'($urandom_range(0, 1));
      next_block = 16'($urandom);
      rot_block  = 16'($urandom);
      lock_ack   = ($urandom_range(0, 2) == 0);
      step("rnd");
      if (m_mode == M_OVER || $urandom_range(0, 299) == 0) async_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
